// File: rtl/nn_eval_pkg.sv
// nn_eval_pkg: shared state encoding, bus widths and default sizes for the MNIST eval sequencer.
package nn_eval_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, MAC, EVAL, DONE} state_e;
  localparam int IMG_ADDR_W = 9;
  localparam int WEIGHT_ADDR_W = 10;
  localparam int CLASS_W = 4;
  localparam int ERR_W = 16;
  localparam int DEF_NUM_OF_DATA = 300;
  localparam int DEF_NUM_OF_WEIGHTS = 784;
endpackage

// File: rtl/nn_eval_sequencer_if.sv
// nn_eval_sequencer_if: host handshake, datapath strobes and status of the eval sequencer.
// run_cycles exists only when NN_EVAL_PERF_CNT_EN is defined.
interface nn_eval_sequencer_if import nn_eval_pkg::*; ();
  logic start;
  logic abort;
  logic [CLASS_W-1:0] prediction;
  logic [CLASS_W-1:0] expected;
  logic [IMG_ADDR_W-1:0] test_addr;
  logic [WEIGHT_ADDR_W-1:0] weight_id;
  logic acc_clr;
  logic acc_en;
  logic busy;
  logic done;
  logic err_pulse;
  logic [ERR_W-1:0] error_counter;
`ifdef NN_EVAL_PERF_CNT_EN
  logic [31:0] run_cycles;
  modport master (output start, abort, prediction, expected,
                  input test_addr, weight_id, acc_clr, acc_en, busy, done, err_pulse, error_counter, run_cycles);
  modport slave (input start, abort, prediction, expected,
                 output test_addr, weight_id, acc_clr, acc_en, busy, done, err_pulse, error_counter, run_cycles);
`else
  modport master (output start, abort, prediction, expected,
                  input test_addr, weight_id, acc_clr, acc_en, busy, done, err_pulse, error_counter);
  modport slave (input start, abort, prediction, expected,
                 output test_addr, weight_id, acc_clr, acc_en, busy, done, err_pulse, error_counter);
`endif
endinterface

// File: rtl/nn_step_timer.sv
// nn_step_timer: loadable down-counter; last is high while the count sits at zero.
module nn_step_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign last = cnt_q == '0;
endmodule

// File: rtl/nn_eval_sequencer.sv
// nn_eval_sequencer: steps images and weight indices for the MNIST datapath and counts misclassifications.
// Optional NN_EVAL_PERF_CNT_EN adds a run_cycles busy-cycle counter.
module nn_eval_sequencer import nn_eval_pkg::*; #(
  parameter int NUM_OF_DATA = DEF_NUM_OF_DATA,
  parameter int NUM_OF_WEIGHTS = DEF_NUM_OF_WEIGHTS,
  parameter int SETTLE_CYCLES = 8,
  parameter int EVAL_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  nn_eval_sequencer_if.slave bus
);
  localparam int MAX_C = SETTLE_CYCLES > EVAL_CYCLES ? SETTLE_CYCLES : EVAL_CYCLES;
  localparam int CNT_W = $clog2(MAX_C) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] EVAL_LD = CNT_W'(EVAL_CYCLES - 1);
  localparam logic [IMG_ADDR_W-1:0] ADDR_LAST = IMG_ADDR_W'(NUM_OF_DATA - 1);
  localparam logic [WEIGHT_ADDR_W-1:0] WID_LAST = WEIGHT_ADDR_W'(NUM_OF_WEIGHTS - 1);
  if (SETTLE_CYCLES < 3 || EVAL_CYCLES < 1) begin : g_param_check
    $error("nn_eval_sequencer: SETTLE_CYCLES must be >= 3 and EVAL_CYCLES >= 1");
  end
  state_e state_q, state_d;
  logic [IMG_ADDR_W-1:0] test_addr_q, test_addr_d;
  logic [WEIGHT_ADDR_W-1:0] weight_id_q, weight_id_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic err_pulse_q, err_pulse_d;
  logic load, last, busy, accept, mism;
  logic [CNT_W-1:0] load_val;
  nn_step_timer #(.W(CNT_W)) u_timer (
    .clk(clk), .reset(reset), .load(load), .load_val(load_val), .last(last)
  );
  assign busy = state_q == CLEAR || state_q == MAC || state_q == EVAL;
  assign accept = (state_q == IDLE || state_q == DONE) && bus.start && !bus.abort;
  assign mism = bus.prediction != bus.expected;
  always_comb begin
    state_d = state_q;
    test_addr_d = test_addr_q;
    weight_id_d = weight_id_q;
    err_cnt_d = err_cnt_q;
    err_pulse_d = 1'b0;
    load = 1'b0;
    load_val = SETTLE_LD;
    // abort wins over every step, so no error is recorded on an aborted EVAL
    if (busy && bus.abort) state_d = IDLE;
    else
      case (state_q)
        IDLE, DONE:
          if (accept) begin
            state_d = CLEAR;
            test_addr_d = '0;
            weight_id_d = '0;
            err_cnt_d = '0;
          end
        CLEAR: begin
          state_d = MAC;
          load = 1'b1;
        end
        MAC:
          if (last) begin
            load = 1'b1;
            if (weight_id_q == WID_LAST) begin
              state_d = EVAL;
              load_val = EVAL_LD;
            end else weight_id_d = weight_id_q + WEIGHT_ADDR_W'(1);
          end
        EVAL:
          if (last) begin
            err_pulse_d = mism;
            err_cnt_d = (mism && err_cnt_q != '1) ? err_cnt_q + ERR_W'(1) : err_cnt_q;
            if (test_addr_q == ADDR_LAST) state_d = DONE;
            else begin
              state_d = CLEAR;
              test_addr_d = test_addr_q + IMG_ADDR_W'(1);
              weight_id_d = '0;
            end
          end
        default: state_d = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      test_addr_q <= '0;
      weight_id_q <= '0;
      err_cnt_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      test_addr_q <= test_addr_d;
      weight_id_q <= weight_id_d;
      err_cnt_q <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  assign bus.test_addr = test_addr_q;
  assign bus.weight_id = weight_id_q;
  assign bus.acc_clr = state_q == CLEAR;
  assign bus.acc_en = state_q == MAC && last;
  assign bus.busy = busy;
  assign bus.done = state_q == DONE;
  assign bus.err_pulse = err_pulse_q;
  assign bus.error_counter = err_cnt_q;
`ifdef NN_EVAL_PERF_CNT_EN
  logic [31:0] run_cycles_q, run_cycles_d;
  always_comb run_cycles_d = accept ? 32'd0 : (busy ? run_cycles_q + 32'd1 : run_cycles_q);
  always_ff @(posedge clk or posedge reset)
    if (reset) run_cycles_q <= '0;
    else run_cycles_q <= run_cycles_d;
  assign bus.run_cycles = run_cycles_q;
`endif
endmodule
